// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the data memory responder: FSM encoding,
// response latency and the wait-state counter width.
package data_mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam int RESP_LATENCY = 2;
   localparam int WCNT_W       = 3;

   // A zero wait-state configuration never loads the counter, so clamp at 0.
   function automatic logic [WCNT_W-1:0] wait_load(input int ws);
      return (ws > 0) ? WCNT_W'(ws - 1) : '0;
   endfunction

endpackage

// File: rtl/resp_wait_cnt.sv
// Wait-state down-counter: load, decrement-to-zero and zero flag; one cycle per step.
// No backpressure; clear has priority over load, load over decrement.
module resp_wait_cnt
   import data_mem_resp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [WCNT_W-1:0] i_load_val,
   input  logic              i_dec,
   input  logic              i_clr,
   output logic              o_zero
);

   logic [WCNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - WCNT_W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding SRAM responder: grant -> SRAM access -> rvalid, 2 cycles after gnt_o.
// Initiator holds req_i until gnt_o; optional address check under DATA_MEM_RESP_ERR_EN.
module data_mem_responder
   import data_mem_resp_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 0,
   parameter int MEM_WORDS   = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_i,
   output logic                    gnt_o,
   output logic                    rvalid_o,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    err_o,
   output logic                    mem_en_o,
   output logic                    mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam logic [WCNT_W-1:0] WS_LOAD   = wait_load(WAIT_STATES);
   localparam logic [31:0]       MEM_LIMIT = 32'(MEM_WORDS);
`ifdef DATA_MEM_RESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   state_e                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic [BE_W-1:0]       r_be;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_err;
   logic                  r_mem_en;
   logic                  r_rvalid;

   logic w_idle_like;
   logic w_cnt_zero;
   logic w_grant;
   logic w_addr_oob;
   logic w_load;
   logic w_dec;
   logic w_clr;

   // RESP accepts a new request exactly like IDLE, giving a grant every 2 cycles.
   assign w_idle_like = (r_state == IDLE) || (r_state == RESP);
   assign w_grant     = !rst && req_i &&
                        ((w_idle_like && (WAIT_STATES == 0)) ||
                         ((r_state == WAIT) && w_cnt_zero));
   assign w_addr_oob  = ERR_EN && (32'(addr_i) >= MEM_LIMIT);
   assign w_load      = !rst && req_i && w_idle_like && (WAIT_STATES != 0);
   assign w_dec       = (r_state == WAIT) && req_i;
   assign w_clr       = (r_state == WAIT) && (!req_i || w_cnt_zero);

   resp_wait_cnt u_wait_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (WS_LOAD),
      .i_dec      (w_dec),
      .i_clr      (w_clr),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_we     <= 1'b0;
         r_be     <= '0;
         r_wdata  <= '0;
         r_err    <= 1'b0;
         r_mem_en <= 1'b0;
         r_rvalid <= 1'b0;
      end else begin
         r_mem_en <= 1'b0;
         r_rvalid <= 1'b0;
         case (r_state)
            IDLE, RESP: r_state <= (req_i && (WAIT_STATES != 0)) ? WAIT : IDLE;
            WAIT:       if (!req_i) r_state <= IDLE;
            ACCESS: begin
               r_state  <= RESP;
               r_rvalid <= 1'b1;
            end
            default:    r_state <= IDLE;
         endcase
         // Grant overrides the state update above; a write with no bytes skips the SRAM.
         if (w_grant) begin
            r_state  <= ACCESS;
            r_addr   <= addr_i;
            r_we     <= we_i;
            r_be     <= be_i;
            r_wdata  <= wdata_i;
            r_err    <= w_addr_oob;
            r_mem_en <= !w_addr_oob && !(we_i && (be_i == '0));
         end
      end
   end

   assign gnt_o       = w_grant;
   assign rvalid_o    = r_rvalid;
   assign err_o       = r_rvalid && r_err;
   assign rdata_o     = (r_rvalid && !r_we && !r_err) ? mem_rdata_i : '0;
   assign mem_en_o    = r_mem_en;
   assign mem_we_o    = r_mem_en && r_we;
   assign mem_addr_o  = r_mem_en ? r_addr  : '0;
   assign mem_be_o    = r_mem_en ? r_be    : '0;
   assign mem_wdata_o = r_mem_en ? r_wdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one zero-wait instance (MEM_WORDS=512) and one
// three-wait instance, each with a behavioural SRAM, plus a transaction-level reference.
module tb_data_mem_responder;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BW = 4;
`ifdef DATA_MEM_RESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic req0, we0, gnt0, rvalid0, err0, men0, mwe0;
   logic [AW-1:0] addr0, maddr0;
   logic [BW-1:0] be0, mbe0;
   logic [DW-1:0] wdata0, rdata0, mwdata0, mrdata0;
   logic req3, we3, gnt3, rvalid3, err3, men3, mwe3;
   logic [AW-1:0] addr3, maddr3;
   logic [BW-1:0] be3, mbe3;
   logic [DW-1:0] wdata3, rdata3, mwdata3, mrdata3;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] sram0 [1024];
   logic [DW-1:0] sram3 [1024];
   logic [DW-1:0] ref0  [1024];
   logic          fill, pl_en;
   logic [AW-1:0] pl_addr;
   logic [DW-1:0] pl_dat;

   data_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0), .MEM_WORDS(512)) dut0 (
      .clk(clk), .rst(rst), .req_i(req0), .gnt_o(gnt0), .rvalid_o(rvalid0),
      .addr_i(addr0), .we_i(we0), .be_i(be0), .wdata_i(wdata0),
      .rdata_o(rdata0), .err_o(err0), .mem_en_o(men0), .mem_we_o(mwe0),
      .mem_addr_o(maddr0), .mem_be_o(mbe0), .mem_wdata_o(mwdata0), .mem_rdata_i(mrdata0));

   data_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(3), .MEM_WORDS(1024)) dut3 (
      .clk(clk), .rst(rst), .req_i(req3), .gnt_o(gnt3), .rvalid_o(rvalid3),
      .addr_i(addr3), .we_i(we3), .be_i(be3), .wdata_i(wdata3),
      .rdata_o(rdata3), .err_o(err3), .mem_en_o(men3), .mem_we_o(mwe3),
      .mem_addr_o(maddr3), .mem_be_o(mbe3), .mem_wdata_o(mwdata3), .mem_rdata_i(mrdata3));

   function automatic logic [DW-1:0] seed_word(input int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // SRAMs: data valid the cycle after enable, junk otherwise.
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 1024; i++) begin
            sram0[i] <= seed_word(i);
            sram3[i] <= seed_word(i);
         end
      end else if (pl_en) begin
         sram0[pl_addr] <= pl_dat;
         sram3[pl_addr] <= pl_dat;
      end
      if (men0) begin
         for (int b = 0; b < BW; b++)
            if (mwe0 && mbe0[b]) sram0[maddr0][8*b +: 8] <= mwdata0[8*b +: 8];
         mrdata0 <= mwe0 ? $urandom : sram0[maddr0];
      end else begin
         mrdata0 <= $urandom;
      end
      if (men3) begin
         for (int b = 0; b < BW; b++)
            if (mwe3 && mbe3[b]) sram3[maddr3][8*b +: 8] <= mwdata3[8*b +: 8];
         mrdata3 <= mwe3 ? $urandom : sram3[maddr3];
      end else begin
         mrdata3 <= $urandom;
      end
   end

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_dat = d;
      ref0[a] = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; fill = 1'b1;
      req0 = 1'b1; addr0 = 10'h005; be0 = 4'hF; req3 = 1'b1; addr3 = 10'h005; be3 = 4'hF;
      for (int i = 0; i < 1024; i++) ref0[i] = seed_word(i);
      #1;
      checks++;
      if ({gnt0, gnt3} !== 2'b00) begin
         errors++; $display("FAIL reset_gnt_same_cycle: got %b required 00", {gnt0, gnt3});
      end
      @(negedge clk); #1;
      checks++;
      if ({gnt0, rvalid0, rdata0, err0, men0, mwe0, maddr0, mbe0, mwdata0} !== '0) begin
         errors++; $display("FAIL reset_outputs_dut0: rv=%b rd=%h men=%b", rvalid0, rdata0, men0);
      end
      checks++;
      if ({gnt3, rvalid3, rdata3, err3, men3, mwe3, maddr3, mbe3, mwdata3} !== '0) begin
         errors++; $display("FAIL reset_outputs_dut3: rv=%b rd=%h men=%b", rvalid3, rdata3, men3);
      end
      @(negedge clk);
      rst = 1'b0; fill = 1'b0; req0 = 1'b0; req3 = 1'b0;
      #1;
      checks++;
      if ({gnt0, rvalid0, men0, gnt3, rvalid3, men3} !== 6'b0) begin
         errors++; $display("FAIL reset_idle: got %b required 000000", {gnt0, rvalid0, men0, gnt3, rvalid3, men3});
      end
   endtask

   task automatic test_read();
      preload(10'h005, 32'hDEADBEEF);
      @(negedge clk);
      req0 = 1'b1; addr0 = 10'h005; we0 = 1'b0; be0 = 4'hF; wdata0 = $urandom;
      #1;
      checks++;
      if (gnt0 !== 1'b1) begin errors++; $display("FAIL read_gnt: got %b required 1", gnt0); end
      @(negedge clk); req0 = 1'b0; #1;
      checks++;
      if ({men0, mwe0, maddr0, rvalid0} !== {1'b1, 1'b0, 10'h005, 1'b0}) begin
         errors++; $display("FAIL read_access: men=%b we=%b addr=%h rv=%b required 1 0 005 0", men0, mwe0, maddr0, rvalid0);
      end
      @(negedge clk); #1;
      checks++;
      if ({rvalid0, err0, rdata0} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
         errors++; $display("FAIL read_resp: rv=%b err=%b rd=%h required 1 0 deadbeef", rvalid0, err0, rdata0);
      end
      @(negedge clk); #1;
      checks++;
      if ({rvalid0, rdata0, men0} !== '0) begin
         errors++; $display("FAIL read_after: rv=%b rd=%h men=%b required zeros", rvalid0, rdata0, men0);
      end
   endtask

   task automatic test_write_read();
      preload(10'h010, 32'h11223344);
      @(negedge clk);
      req0 = 1'b1; addr0 = 10'h010; we0 = 1'b1; be0 = 4'b0011; wdata0 = 32'hAABBCCDD;
      #1;
      checks++;
      if (gnt0 !== 1'b1) begin errors++; $display("FAIL write_gnt: got %b required 1", gnt0); end
      @(negedge clk); req0 = 1'b0; #1;
      checks++;
      if ({men0, mwe0, maddr0, mbe0, mwdata0} !== {1'b1, 1'b1, 10'h010, 4'b0011, 32'hAABBCCDD}) begin
         errors++; $display("FAIL write_access: men=%b we=%b addr=%h be=%b wd=%h", men0, mwe0, maddr0, mbe0, mwdata0);
      end
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; be0 = 4'hF; wdata0 = $urandom;
      #1;
      checks++;
      if ({rvalid0, rdata0, gnt0} !== {1'b1, 32'h0, 1'b1}) begin
         errors++; $display("FAIL write_resp_b2b: rv=%b rd=%h gnt=%b required 1 0 1", rvalid0, rdata0, gnt0);
      end
      @(negedge clk); req0 = 1'b0; #1;
      checks++;
      if ({men0, mwe0, gnt0} !== 3'b100) begin
         errors++; $display("FAIL readback_access: men/we/gnt=%b required 100", {men0, mwe0, gnt0});
      end
      @(negedge clk); #1;
      checks++;
      if ({rvalid0, rdata0} !== {1'b1, 32'h1122CCDD}) begin
         errors++; $display("FAIL readback_data: rv=%b rd=%h required 1 1122ccdd", rvalid0, rdata0);
      end
      ref0[10'h010] = 32'h1122CCDD;
   endtask

   task automatic test_err();
      logic [AW-1:0] a [2];
      logic [DW-1:0] d [2];
      logic          oob;
      a[0] = 10'h200; d[0] = 32'hCAFEF00D;
      a[1] = 10'h1FF; d[1] = 32'h0BADC0DE;
      for (int t = 0; t < 2; t++) begin
         preload(a[t], d[t]);
         oob = ERR_EN && (a[t] >= 10'h200);
         @(negedge clk);
         req0 = 1'b1; addr0 = a[t]; we0 = 1'b0; be0 = 4'hF;
         #1;
         checks++;
         if (gnt0 !== 1'b1) begin errors++; $display("FAIL err_gnt[%0d]: got %b required 1", t, gnt0); end
         @(negedge clk); req0 = 1'b0; #1;
         checks++;
         if (men0 !== !oob) begin errors++; $display("FAIL err_men[%0d]: got %b required %b", t, men0, !oob); end
         @(negedge clk); #1;
         checks++;
         if ({rvalid0, err0, rdata0} !== {1'b1, oob, (oob ? 32'h0 : d[t])}) begin
            errors++; $display("FAIL err_resp[%0d]: rv=%b err=%b rd=%h required 1 %b %h", t, rvalid0, err0, rdata0, oob, (oob ? 32'h0 : d[t]));
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req0 = 1'b1; addr0 = 10'h005; we0 = 1'b0; be0 = 4'hF;
      #1;
      checks++;
      if (gnt0 !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: got %b required 1", gnt0); end
      @(negedge clk); req0 = 1'b0; rst = 1'b1; #1;
      checks++;
      if (men0 !== 1'b1) begin errors++; $display("FAIL rstmid_access: men=%b required 1", men0); end
      @(negedge clk); rst = 1'b0; #1;
      checks++;
      if ({gnt0, rvalid0, rdata0, err0, men0, mwe0, maddr0, mbe0, mwdata0} !== '0) begin
         errors++; $display("FAIL rstmid_outputs: rv=%b rd=%h men=%b required zeros", rvalid0, rdata0, men0);
      end
      @(negedge clk);
      req0 = 1'b1;
      #1;
      checks++;
      if ({gnt0, rvalid0} !== 2'b10) begin
         errors++; $display("FAIL rstmid_new_req: gnt/rv=%b required 10", {gnt0, rvalid0});
      end
      @(negedge clk); req0 = 1'b0; #1;
      @(negedge clk); #1;
      checks++;
      if ({rvalid0, rdata0} !== {1'b1, ref0[10'h005]}) begin
         errors++; $display("FAIL rstmid_resp: rv=%b rd=%h required 1 %h", rvalid0, rdata0, ref0[10'h005]);
      end
   endtask

   task automatic test_wait_states();
      bit          got;
      int          gnt_at, rv_at, seen;
      logic [DW-1:0] rv_dat;
      for (int run = 0; run < 3; run++) begin
         if (run == 1) begin
            seen = 0;
            @(negedge clk);
            req3 = 1'b1; addr3 = 10'h022; we3 = 1'b0; be3 = 4'hF;
            #1; seen += int'(gnt3 | rvalid3 | men3);
            for (int k = 0; k < 10; k++) begin
               @(negedge clk); req3 = 1'b0; #1;
               seen += int'(gnt3 | rvalid3 | men3);
            end
            checks++;
            if (seen != 0) begin errors++; $display("FAIL ws3_abort: %0d active cycles, required 0", seen); end
         end else begin
            got = 1'b0; gnt_at = -1; rv_at = -1; rv_dat = '0;
            @(negedge clk);
            req3 = 1'b1; addr3 = 10'h021; we3 = 1'b0; be3 = 4'hF;
            for (int k = 0; k < 16 && !got; k++) begin
               #1;
               if (gnt3 === 1'b1) begin got = 1'b1; gnt_at = k; end
               else @(negedge clk);
            end
            checks++;
            if (gnt_at != 3) begin errors++; $display("FAIL ws3_gnt_delay[%0d]: got %0d required 3", run, gnt_at); end
            got = 1'b0;
            for (int k = 1; k <= 8; k++) begin
               @(negedge clk);
               req3 = 1'b0;
               #1;
               if (!got && rvalid3 === 1'b1) begin got = 1'b1; rv_at = k; rv_dat = rdata3; end
            end
            checks++;
            if (rv_at != data_mem_resp_pkg::RESP_LATENCY || rv_dat !== seed_word(32'h21)) begin
               errors++; $display("FAIL ws3_resp[%0d]: latency %0d data %h required %0d %h", run, rv_at, rv_dat, data_mem_resp_pkg::RESP_LATENCY, seed_word(32'h21));
            end
         end
      end
   endtask

   task automatic test_random();
      bit            pending, exp_gnt, exp_rv, g_we, g_err, g_men;
      logic [AW-1:0] c_addr, g_addr;
      logic          c_we;
      logic [BW-1:0] c_be, g_be;
      logic [DW-1:0] c_wd, g_wd, g_rdata;
      logic [1+1+AW+BW+DW-1:0] exp_mem;
      logic [1+1+DW-1:0]       exp_resp;
      int            g_cyc;
      pending = 1'b0; g_cyc = -10;
      c_addr = '0; c_we = 1'b0; c_be = '0; c_wd = '0;
      g_addr = '0; g_we = 1'b0; g_be = '0; g_wd = '0; g_err = 1'b0; g_men = 1'b0; g_rdata = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (!pending && $urandom_range(0, 3) != 0) begin
            pending = 1'b1;
            case ($urandom_range(0, 2))
               0:       c_addr = 10'h000;
               1:       c_addr = 10'h1FC;
               default: c_addr = 10'h3F8;
            endcase
            c_addr = c_addr + 10'($urandom_range(0, 7));
            c_we   = 1'($urandom_range(0, 1));
            c_be   = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            c_wd   = $urandom;
         end
         req0 = pending; addr0 = c_addr; we0 = c_we; be0 = c_be; wdata0 = c_wd;
         #1;
         exp_gnt = pending && (cyc != g_cyc + 1);
         checks++;
         if (gnt0 !== exp_gnt) begin errors++; $display("FAIL rnd_gnt@%0d: got %b required %b", cyc, gnt0, exp_gnt); end
         exp_mem = (cyc == g_cyc + 1 && g_men) ? {1'b1, g_we, g_addr, g_be, g_wd} : '0;
         checks++;
         if ({men0, mwe0, maddr0, mbe0, mwdata0} !== exp_mem) begin
            errors++; $display("FAIL rnd_mem@%0d: got %h required %h", cyc, {men0, mwe0, maddr0, mbe0, mwdata0}, exp_mem);
         end
         exp_rv   = (cyc == g_cyc + 2);
         exp_resp = exp_rv ? {1'b1, g_err, g_rdata} : '0;
         checks++;
         if ({rvalid0, err0, rdata0} !== exp_resp) begin
            errors++; $display("FAIL rnd_resp@%0d: got %h required %h", cyc, {rvalid0, err0, rdata0}, exp_resp);
         end
         if (exp_gnt) begin
            g_cyc = cyc; g_addr = c_addr; g_we = c_we; g_be = c_be; g_wd = c_wd;
            g_err   = ERR_EN && (c_addr >= 10'h200);
            g_men   = !g_err && !(c_we && c_be == 4'h0);
            g_rdata = (c_we || g_err) ? 32'h0 : ref0[c_addr];
            if (c_we && !g_err)
               for (int b = 0; b < BW; b++)
                  if (c_be[b]) ref0[c_addr][8*b +: 8] = c_wd[8*b +: 8];
            pending = 1'b0;
         end
      end
      @(negedge clk);
      req0 = 1'b0;
   endtask

   initial begin
      rst = 1'b0; fill = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
      req0 = 1'b0; addr0 = '0; we0 = 1'b0; be0 = '0; wdata0 = '0;
      req3 = 1'b0; addr3 = '0; we3 = 1'b0; be3 = '0; wdata3 = '0;
      test_reset();
      test_read();
      test_write_read();
      test_err();
      test_reset_mid();
      test_wait_states();
      test_random();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
